// File: rtl/ps2_host_tx_if.sv
// Request/status handshake and PS/2 pin group for the host-to-device transmitter.
// The pins are the resolved open-drain line levels; the _oe signals pull them low.
interface ps2_host_tx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       error;

    // Requester side (keyboard controller / bench)
    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, ack_ok, error,
        input  ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe
    );

    // Transmitter side
    modport slave (
        input  ps2_clk, ps2_data, tx_data, tx_valid,
        output ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, ack_ok, error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start, 8 data bits LSB first,
// odd parity, stop, then checks the device acknowledge bit. Open-drain pins are
// driven through the _oe outputs (1 = pull low).
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic          clk,
    input logic          clrn,
    ps2_host_tx_if.slave bus
);

    localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                     INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] InhLast = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StInhibit  = 3'd1;
    localparam logic [2:0] StStart    = 3'd2;
    localparam logic [2:0] StSend     = 3'd3;
    localparam logic [2:0] StAck      = 3'd4;
    localparam logic [2:0] StWaitIdle = 3'd5;
    localparam logic [2:0] StDone     = 3'd6;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      n_q, n_d;
    logic [7:0]      data_q, data_d;
    logic            parity_q, parity_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            ack_ok_q, ack_ok_d;
    logic            error_q, error_d;
    logic [2:0]      clk_sync_q;
    logic [1:0]      data_sync_q;
    logic            clk_fall;

    // Previous synchronised sample high, current low
    assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];

    // Pin synchronisers; reset to the idle (released) line level
    always_ff @(posedge clk) begin
        if (clrn) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], bus.ps2_clk};
            data_sync_q <= {data_sync_q[0], bus.ps2_data};
        end
    end

    // Transaction sequencing and next-state for every register
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        data_d    = data_q;
        parity_d  = parity_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ack_ok_d  = ack_ok_q;
        error_d   = error_q;
        case (state_q)
            StIdle: begin
                if (bus.tx_valid) begin
                    data_d   = bus.tx_data;
                    parity_d = ~^bus.tx_data;
                    ack_ok_d = 1'b0;
                    error_d  = 1'b0;
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == InhLast) begin
                    data_oe_d = 1'b1;
                    state_d   = StStart;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStart: begin
                clk_oe_d = 1'b0;
                cnt_d    = '0;
                n_d      = '0;
                state_d  = StSend;
            end
            StSend, StAck, StWaitIdle: begin
                // Timeout is checked first so it wins over a coincident edge
                if (cnt_q == TmoLast) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    ack_ok_d  = 1'b0;
                    error_d   = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == StSend) begin
                        if (clk_fall) begin
                            n_d = n_q + 4'd1;
                            if (n_q < 4'd8) begin
                                data_oe_d = ~data_q[n_q[2:0]];
                            end else if (n_q == 4'd8) begin
                                data_oe_d = ~parity_q;
                            end else begin
                                data_oe_d = 1'b0;
                                state_d   = StAck;
                            end
                        end
                    end else if (state_q == StAck) begin
                        if (clk_fall) begin
                            ack_ok_d = ~data_sync_q[1];
                            state_d  = StWaitIdle;
                        end
                    end else if (clk_sync_q[1] && data_sync_q[1]) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (clrn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            n_q       <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ack_ok_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ack_ok_q  <= ack_ok_d;
            error_q   <= error_d;
        end
    end

    assign bus.ps2_clk_oe  = clk_oe_q;
    assign bus.ps2_data_oe = data_oe_q;
    assign bus.tx_ready    = (state_q == StIdle);
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = (state_q == StDone);
    assign bus.ack_ok      = ack_ok_q;
    assign bus.error       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// compares the received bits, status and timing against values derived from the
// frame format (data LSB first, odd parity, stop high, device ack).
module tb_ps2_host_tx;

    localparam int unsigned Inh = 20;
    localparam int unsigned Tmo = 200;

    logic clk = 1'b0;
    logic clrn = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;

    always #5 clk = ~clk;

    ps2_host_tx_if bus ();

    // Wired-AND open-drain lines
    assign bus.ps2_clk  = dev_clk & ~bus.ps2_clk_oe;
    assign bus.ps2_data = dev_data & ~bus.ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(Inh),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk (clk),
        .clrn(clrn),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int starts = 0;
    logic clk_oe_prev = 1'b0;

    // Count done pulses and transaction starts (rising clk_oe)
    always @(posedge clk) begin
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
        if (bus.ps2_clk_oe === 1'b1 && clk_oe_prev === 1'b0) starts <= starts + 1;
        clk_oe_prev <= bus.ps2_clk_oe;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Line levels the device should see: data LSB first, odd parity, stop high
    function automatic logic [9:0] exp_frame(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0);
        return {1'b1, par, d};
    endfunction

    // Device clocks `edges` bits out of the host; with all 10, also runs the ack bit
    task automatic device(input int edges, input int h, input bit do_ack,
                          output logic [9:0] frame);
        frame = '0;
        tick(3);
        for (int k = 0; k < edges; k++) begin
            dev_clk = 1'b0;
            tick(h);
            frame[k] = bus.ps2_data;
            dev_clk = 1'b1;
            tick(h);
        end
        if (edges == 10) begin
            if (do_ack) dev_data = 1'b0;
            tick(1);
            dev_clk = 1'b0;
            tick(h);
            dev_clk  = 1'b1;
            dev_data = 1'b1;
        end
    endtask

    task automatic start_tx(input logic [7:0] d, input bit hold);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        tick(1);
        if (!hold) bus.tx_valid = 1'b0;
        check("accept_busy", bus.busy, 1);
        check("accept_ready", bus.tx_ready, 0);
        check("accept_clk_oe", bus.ps2_clk_oe, 1);
    endtask

    // Walk inhibit and start; returns in the first SEND cycle
    task automatic through_start();
        int n;
        n = 0;
        while (bus.ps2_clk_oe === 1'b1 && bus.ps2_data_oe === 1'b0 && n < 1000) begin
            n++;
            tick(1);
        end
        check("inhibit_len", n, Inh);
        check("start_clk_oe", bus.ps2_clk_oe, 1);
        check("start_data_oe", bus.ps2_data_oe, 1);
        tick(1);
        check("send_clk_oe", bus.ps2_clk_oe, 0);
        check("send_start_bit", bus.ps2_data_oe, 1);
    endtask

    task automatic finish_tx(input bit exp_ack, input bit exp_err, input bit chk_delay);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 400) begin
            n++;
            tick(1);
        end
        check("done_seen", bus.done, 1);
        if (chk_delay) check("timeout_delay", n, Tmo);
        check("done_ack_ok", bus.ack_ok, exp_ack);
        check("done_error", bus.error, exp_err);
        check("done_clk_oe", bus.ps2_clk_oe, 0);
        check("done_data_oe", bus.ps2_data_oe, 0);
        tick(1);
        check("done_width", bus.done, 0);
        check("ready_after_done", bus.tx_ready, 1);
    endtask

    task automatic run_tx(input logic [7:0] d, input bit do_ack, input int h);
        logic [9:0] frame;
        start_tx(d, 1'b0);
        through_start();
        device(10, h, do_ack, frame);
        check("frame", frame, exp_frame(d));
        finish_tx(do_ack, 1'b0, 1'b0);
        tick(2);
        check("status_hold", bus.ack_ok, do_ack);
    endtask

    initial begin
        logic [9:0] frame;
        logic [7:0] d;
        int d0;
        int s0;

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        tick(3);
        check("rst_ready", bus.tx_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_clk_oe", bus.ps2_clk_oe, 0);
        check("rst_data_oe", bus.ps2_data_oe, 0);
        check("rst_ack_ok", bus.ack_ok, 0);
        check("rst_error", bus.error, 0);
        clrn = 1'b0;
        tick(2);

        // Directed: LED command, parity corners, NACK
        run_tx(8'hED, 1'b1, 5);
        run_tx(8'h00, 1'b1, 4);
        run_tx(8'h01, 1'b1, 6);
        run_tx(8'h5A, 1'b0, 5);

        // Randomized bytes, ack/nack and device clock speed
        for (int i = 0; i < 6; i++) begin
            run_tx(8'($urandom), ($urandom_range(0, 3) != 0), int'($urandom_range(4, 6)));
        end

        // Device never clocks
        start_tx(8'hA5, 1'b0);
        through_start();
        finish_tx(1'b0, 1'b1, 1'b1);

        // Reset in the middle of the data bits
        d = 8'($urandom);
        start_tx(d, 1'b0);
        through_start();
        device(5, 5, 1'b0, frame);
        check("partial_frame", frame[4:0], d[4:0]);
        d0 = done_cnt;
        clrn = 1'b1;
        tick(1);
        check("rst_mid_clk_oe", bus.ps2_clk_oe, 0);
        check("rst_mid_data_oe", bus.ps2_data_oe, 0);
        check("rst_mid_ready", bus.tx_ready, 1);
        clrn = 1'b0;
        tick(3);
        check("rst_mid_no_done", done_cnt, d0);

        // tx_valid held high: one accept per tx_ready window
        s0 = starts;
        d  = 8'($urandom);
        start_tx(d, 1'b1);
        through_start();
        device(10, 5, 1'b1, frame);
        check("hold_frame1", frame, exp_frame(d));
        finish_tx(1'b1, 1'b0, 1'b0);
        tick(1);
        check("hold_reaccept", bus.busy, 1);
        bus.tx_valid = 1'b0;
        through_start();
        device(10, 5, 1'b1, frame);
        check("hold_frame2", frame, exp_frame(d));
        finish_tx(1'b1, 1'b0, 1'b0);
        tick(3);
        check("hold_starts", starts - s0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte per request to the keyboard, for example 0xED followed by an LED mask so the Caps Lock LED follows the `cap_on` state. The byte goes out on the same open-drain `ps2_clk`/`ps2_data` pair the scan-code receiver listens on. The block runs the full host request-to-send sequence (inhibit, start, 8 data bits, odd parity, stop) and checks the device's acknowledge bit. While `busy` is high, the keyboard input path must ignore received bytes.

## Interface
- `INHIBIT_CYCLES`, default 5000: number of `clk` cycles `ps2_clk` is held low before the start bit (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 1000000: limit, counted from release of `ps2_clk`, for the device to finish clocking the frame (20 ms at 50 MHz).
- `clk`  in  1  system clock. One clock domain for the whole block.
- `clrn`  in  1  reset. Synchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock pin level, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin level, asynchronous.
- `ps2_clk_oe`  out  1  1 = pull the PS/2 clock line low. 0 = release it.
- `ps2_data_oe`  out  1  1 = pull the PS/2 data line low. 0 = release it.
- `tx_data`  in  8  command byte to send.
- `tx_valid`  in  1  send request.
- `tx_ready`  out  1  block is idle and can accept a request.
- `busy`  out  1  a transaction is in progress.
- `done`  out  1  one-cycle pulse when a transaction ends.
- `ack_ok`  out  1  the device acknowledged the last transaction.
- `error`  out  1  the last transaction timed out.

## Operation
- **Input synchronisers:** `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser.
  - A third flop on the clock path gives the falling-edge detect: previous sample 1, current sample 0.
  - Edge detection is used only in states SEND and ACK.
- **Accept:** the request is accepted when `tx_valid` and `tx_ready` are both high on a rising edge of `clk`.
  - On accept: latch `tx_data`, compute parity as the XNOR of the 8 bits (odd parity), clear `ack_ok` and `error`, go to INHIBIT.
- **IDLE:** `ps2_clk_oe` = 0, `ps2_data_oe` = 0, `tx_ready` = 1, `busy` = 0.
- **INHIBIT:** `ps2_clk_oe` = 1, `ps2_data_oe` = 0 for exactly `INHIBIT_CYCLES` cycles, then go to START.
- **START:** `ps2_clk_oe` = 1, `ps2_data_oe` = 1 for 1 cycle, then go to SEND.
  - On entry to SEND, clear the bit counter `n` and the timeout counter.
- **SEND:** `ps2_clk_oe` = 0. `ps2_data_oe` holds the start bit (1) until the first falling edge.
  - On each detected falling edge, increment `n` (1..10) and update `ps2_data_oe`:
    - `n` = 1..8: `~tx_data[n-1]`, LSB first.
    - `n` = 9: `~parity`.
    - `n` = 10: 0 (stop bit, line released). Go to ACK.
- **ACK:** on the next falling edge, sample the synchronised data.
  - Sampled 0: set `ack_ok` = 1.
  - Sampled 1: `ack_ok` stays 0 (NACK).
  - Then go to WAIT_IDLE.
- **WAIT_IDLE:** wait until the synchronised clock and data are both 1, then pulse `done`, go to IDLE.
- **Timeout:** the counter runs during SEND, ACK and WAIT_IDLE.
  - On reaching `TIMEOUT_CYCLES`: release both lines, set `error` = 1, `ack_ok` = 0, pulse `done`, go to IDLE.
- **Status hold:** `ack_ok` and `error` hold their values until the next accept.
- **Ignored input:** `tx_valid` is ignored while `busy` is high. No queueing.

## Timing
- **Reset values:** all outputs 0 except `tx_ready` = 1. State IDLE, all counters 0.
- **Reset mid-transaction:** both `_oe` outputs are 0 in the cycle after `clrn` is sampled high. No `done` pulse.
- **Accept to bus activity:** `ps2_clk_oe` rises 1 cycle after the accept edge. `tx_ready` falls and `busy` rises in the same cycle.
- **Start bit:** `ps2_data_oe` rises `INHIBIT_CYCLES` + 1 cycles after the accept edge. `ps2_clk_oe` falls 1 cycle later.
- **Data update latency:** `ps2_data_oe` changes 3 `clk` cycles after a pin falling edge: 2 synchroniser cycles plus 1 register cycle. This is well inside the ≥30 µs PS/2 low phase.
- **Done and status timing:**
  - `done` is high exactly 1 cycle.
  - `ack_ok`/`error` are valid in the same cycle as `done`.
  - `tx_ready` returns to 1 in the cycle after `done`.
- **Back-to-back requests:** a new request can be accepted in the cycle `tx_ready` returns to 1.
- **Glitch filtering:** a falling edge in INHIBIT or START is not counted, because the block itself is holding the clock low.
- **Timeout/edge collision:** if the timeout expires in the same cycle as an edge, the timeout wins.

## Test plan
- **Normal 0xED:** `tx_data` = 0xED, device model ACKs.
  - Expected `ps2_data_oe` after edges 1..9: ~{1,0,1,1,0,1,1,1}, then parity 1 → `oe` 0. Stop → `oe` 0.
  - Then `ack_ok` = 1, `error` = 0, 1-cycle `done`.
- **Parity cases:**
  - 0x00 → parity bit 1 (`oe` 0 at edge 9).
  - 0x01 → parity bit 0 (`oe` 1 at edge 9).
  - Both transactions ACKed.
- **Inhibit length:** with `INHIBIT_CYCLES` = 20, `ps2_clk_oe` is high for exactly 21 cycles, with `ps2_data_oe` rising on the 21st.
- **NACK:** device leaves data high at edge 11 → `ack_ok` = 0, `error` = 0, `done` pulses, block returns to IDLE.
- **Timeout:** with `TIMEOUT_CYCLES` = 200, device never clocks → `done` exactly 200 cycles after SEND entry, `error` = 1, both `_oe` = 0.
- **Reset and ignored requests:**
  - `clrn` asserted after edge 5 → both `_oe` = 0 and `tx_ready` = 1 one cycle later, no `done` pulse.
  - `tx_valid` held high through a transaction → exactly one transaction per `tx_ready` window.
